caf_search_ctrl: RTL and testbench
==================================

# caf_search_ctrl

Sequencer for the cross-ambiguity-function (CAF) search. It steps a frequency-bin selector through `freq_bins` offsets and launches one correlation run per bin. For each bin it accepts the per-bin `arg_max` result (peak magnitude plus time index) and keeps the running global peak. It reports the winning (frequency, time, magnitude) triple on a valid/ready output. It sits between the host/start logic and the frequency-shift → correlator → `arg_max` datapath.

## Interface
- `freq_bins`, 8: number of frequency bins searched, ≥1
- `freq_bits`, 3: width of bin selector, ≥ clog2(freq_bins), minimum 1
- `index_bits`, 4: `arg_max` index width is `index_bits+1`
- `mag_bits`, 24: peak magnitude width (equals `i_bits+q_bits` of `arg_max`)
- `timeout_cycles`, 1024: watchdog limit in WAIT (used only with macro)

Ports:
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: level-sampled request to begin a search
- `busy` out 1: high from accepted start until output handshake completes
- `freq_sel` out freq_bits: current bin to frequency shifter
- `run_start` out 1: one-cycle pulse launching correlation of bin `freq_sel`
- `in_tvalid` in 1: `arg_max` result valid
- `in_tready` out 1: controller ready for a result
- `in_max` in mag_bits: per-bin peak magnitude (unsigned)
- `in_index` in index_bits+1: per-bin peak time index
- `out_tvalid` out 1: search result valid
- `out_tready` in 1: downstream ready
- `out_max` out mag_bits: global peak magnitude
- `out_index` out index_bits+1: time index of global peak
- `out_freq` out freq_bits: bin of global peak
- `timeout_err` out 1: sticky, at least one bin timed out this search

## Operation
- FSM: IDLE, LAUNCH, WAIT, UPDATE, EMIT.
- IDLE: `start`=1 → clear best registers, clear `timeout_err`, set `freq_sel`=0, go to LAUNCH.
- LAUNCH: `run_start`=1 for exactly this cycle → WAIT.
- WAIT: `in_tready`=1. On `in_tvalid & in_tready`, capture `in_max` and `in_index` → UPDATE. `in_tvalid` in any other state is ignored; `in_tready`=0 there.
- UPDATE:
  - Bin 0 loads best unconditionally. Later bins replace best only when `in_max > best_max` (unsigned, strict). Ties keep the lower bin.
  - If `freq_sel == freq_bins-1` → EMIT; otherwise increment `freq_sel` → LAUNCH.
- EMIT: `out_tvalid`=1. `out_*` stay stable until `out_tready` is sampled high. Then `out_tvalid` drops → IDLE.
- `start` while not IDLE is ignored and not queued.
- `freq_bins`=1: one LAUNCH/WAIT/UPDATE, then EMIT.
- `freq_sel` never exceeds `freq_bins-1`. It holds its last value in EMIT and IDLE until the next start.

## Timing
- Reset values: `busy`=0, `freq_sel`=0, `run_start`=0, `in_tready`=0, `out_tvalid`=0, `out_max`=0, `out_index`=0, `out_freq`=0, `timeout_err`=0; FSM=IDLE.
- `start` sampled high at edge k → `busy` and `run_start` high in cycle k+1.
- Result accepted at edge j → UPDATE in cycle j+1 → next `run_start` (or `out_tvalid`) in cycle j+2.
- Per-bin overhead excluding datapath latency: 3 cycles.
- `out_tready` high on the first EMIT cycle → single-cycle `out_tvalid`, IDLE next cycle. `start` is sampled again from IDLE.
- `rst_n` low mid-search: immediate abort, all outputs to reset values. No `out_tvalid` for the abandoned search.

## Configuration
- `CAF_SEARCH_TIMEOUT_EN` defined:
  - A watchdog counts WAIT cycles and restarts on each LAUNCH.
  - When the count reaches `timeout_cycles` with no result, the bin is skipped: no best update, `timeout_err` set, normal UPDATE transition. `in_tready` drops in that UPDATE cycle.
  - If bin 0 times out, the first non-timed-out bin loads best unconditionally.
  - If all bins time out, EMIT with `out_max`=0, `out_index`=0, `out_freq`=0.
- Not defined: WAIT waits indefinitely; `timeout_err` tied 0; `timeout_cycles` unused.

## Structure
- Package `caf_search_pkg`: FSM state enum `caf_search_state_t` and a clog2-based width helper for `freq_bits`.
- One sub-module, `caf_search_timer`: watchdog counter with load/clear/expire. It is instantiated only under `CAF_SEARCH_TIMEOUT_EN`.

## Test plan
- freq_bins=4, per-bin `in_max` = 10, 50, 30, 20 with `in_index` = 3, 7, 1, 9 → single `out_tvalid` with max=50, index=7, freq=1. Exactly 4 `run_start` pulses, `freq_sel` 0..3.
- Ties: `in_max` = 40, 40, 40, 40 → freq=0, index from bin 0. All zeros → max=0, freq=0, index from bin 0.
- Backpressure: hold `out_tready`=0 for 5 cycles in EMIT → outputs stable, `busy`=1. Assert `start` during the hold → ignored, no new `run_start`.
- Reset mid-search: deassert `rst_n` during WAIT of bin 2 → all outputs 0 asynchronously. After release and `start`, a fresh search begins at bin 0.
- Spurious input: `in_tvalid` pulses in IDLE and LAUNCH → not accepted, best unchanged.
- With `CAF_SEARCH_TIMEOUT_EN` and `timeout_cycles`=16: bin 1 never answers → after 16 WAIT cycles proceeds to bin 2, `timeout_err`=1, result excludes bin 1.

Source files
------------

// File: rtl/caf_search_pkg.sv
// Shared types and helpers for the CAF search sequencer.
package caf_search_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLaunch = 3'd1,
    StWait   = 3'd2,
    StUpdate = 3'd3,
    StEmit   = 3'd4
  } caf_search_state_t;

  // Width of a selector able to address n bins, never narrower than 1 bit
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/caf_search_ctrl_if.sv
// Handshake and result bus between the CAF search sequencer and its neighbours.
// slave: the sequencer's view; master: the host/datapath view.
interface caf_search_ctrl_if #(
  parameter int unsigned freq_bits  = 3,
  parameter int unsigned index_bits = 4,
  parameter int unsigned mag_bits   = 24
);
  logic                  start;
  logic                  busy;
  logic [freq_bits-1:0]  freq_sel;
  logic                  run_start;
  logic                  in_tvalid;
  logic                  in_tready;
  logic [mag_bits-1:0]   in_max;
  logic [index_bits:0]   in_index;
  logic                  out_tvalid;
  logic                  out_tready;
  logic [mag_bits-1:0]   out_max;
  logic [index_bits:0]   out_index;
  logic [freq_bits-1:0]  out_freq;
  logic                  timeout_err;

  modport slave (
    input  start, in_tvalid, in_max, in_index, out_tready,
    output busy, freq_sel, run_start, in_tready, out_tvalid, out_max, out_index, out_freq,
           timeout_err
  );

  modport master (
    output start, in_tvalid, in_max, in_index, out_tready,
    input  busy, freq_sel, run_start, in_tready, out_tvalid, out_max, out_index, out_freq,
           timeout_err
  );
endinterface

// File: rtl/caf_search_timer.sv
// Per-bin watchdog: restarts on load, counts while enabled, flags the last allowed cycle.
module caf_search_timer #(
  parameter int unsigned limit = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expired
);
  localparam int unsigned cnt_bits = (limit > 1) ? $clog2(limit) : 1;

  logic [cnt_bits-1:0] count_q;

  // Count waited cycles; saturate at the expiry value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (count_en && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  // High on the limit-th waited cycle, counting the first as zero
  assign expired = (count_q == cnt_bits'(limit - 1));
endmodule

// File: rtl/caf_search_ctrl.sv
// CAF search sequencer: steps the frequency bins, launches one correlation per bin,
// keeps the running global peak and presents it on a valid/ready output.
// Optional per-bin watchdog enabled by defining CAF_SEARCH_TIMEOUT_EN.
module caf_search_ctrl
  import caf_search_pkg::*;
#(
  parameter int unsigned freq_bins      = 8,
  parameter int unsigned freq_bits      = sel_width(freq_bins),
  parameter int unsigned index_bits     = 4,
  parameter int unsigned mag_bits       = 24,
  parameter int unsigned timeout_cycles = 1024
) (
  input logic              clk,
  input logic              rst_n,
  caf_search_ctrl_if.slave bus
);
  localparam logic [freq_bits-1:0] last_sel = freq_bits'(freq_bins - 1);

  caf_search_state_t    state_q, state_d;
  logic [freq_bits-1:0] freq_sel_q, freq_sel_d;
  logic [mag_bits-1:0]  best_max_q, best_max_d;
  logic [index_bits:0]  best_index_q, best_index_d;
  logic [freq_bits-1:0] best_freq_q, best_freq_d;
  logic                 best_valid_q, best_valid_d;
  logic [mag_bits-1:0]  cap_max_q, cap_max_d;
  logic [index_bits:0]  cap_index_q, cap_index_d;
  logic                 cap_timeout_q, cap_timeout_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 timed_out;

`ifdef CAF_SEARCH_TIMEOUT_EN
  logic expired;

  caf_search_timer #(
    .limit(timeout_cycles)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q == StLaunch),
    .count_en(state_q == StWait),
    .expired (expired)
  );

  // A result arriving on the expiry cycle still wins over the timeout
  assign timed_out = (state_q == StWait) && !bus.in_tvalid && expired;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (timeout_cycles != 0);
  assign timed_out          = 1'b0;
`endif

  // Next-state logic for the sequencer and its datapath registers
  always_comb begin
    state_d       = state_q;
    freq_sel_d    = freq_sel_q;
    best_max_d    = best_max_q;
    best_index_d  = best_index_q;
    best_freq_d   = best_freq_q;
    best_valid_d  = best_valid_q;
    cap_max_d     = cap_max_q;
    cap_index_d   = cap_index_q;
    cap_timeout_d = cap_timeout_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          best_max_d    = '0;
          best_index_d  = '0;
          best_freq_d   = '0;
          best_valid_d  = 1'b0;
          timeout_err_d = 1'b0;
          freq_sel_d    = '0;
          state_d       = StLaunch;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (bus.in_tvalid) begin
          cap_max_d     = bus.in_max;
          cap_index_d   = bus.in_index;
          cap_timeout_d = 1'b0;
          state_d       = StUpdate;
        end else if (timed_out) begin
          cap_timeout_d = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = StUpdate;
        end
      end
      StUpdate: begin
        // First answered bin loads unconditionally; strict compare keeps the lower bin on ties
        if (!cap_timeout_q && (!best_valid_q || (cap_max_q > best_max_q))) begin
          best_max_d   = cap_max_q;
          best_index_d = cap_index_q;
          best_freq_d  = freq_sel_q;
          best_valid_d = 1'b1;
        end
        if (freq_sel_q == last_sel) begin
          state_d = StEmit;
        end else begin
          freq_sel_d = freq_sel_q + 1'b1;
          state_d    = StLaunch;
        end
      end
      StEmit: begin
        if (bus.out_tready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      freq_sel_q    <= '0;
      best_max_q    <= '0;
      best_index_q  <= '0;
      best_freq_q   <= '0;
      best_valid_q  <= 1'b0;
      cap_max_q     <= '0;
      cap_index_q   <= '0;
      cap_timeout_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      freq_sel_q    <= freq_sel_d;
      best_max_q    <= best_max_d;
      best_index_q  <= best_index_d;
      best_freq_q   <= best_freq_d;
      best_valid_q  <= best_valid_d;
      cap_max_q     <= cap_max_d;
      cap_index_q   <= cap_index_d;
      cap_timeout_q <= cap_timeout_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.run_start   = (state_q == StLaunch);
  assign bus.in_tready   = (state_q == StWait);
  assign bus.out_tvalid  = (state_q == StEmit);
  assign bus.freq_sel    = freq_sel_q;
  assign bus.out_max     = best_max_q;
  assign bus.out_index   = best_index_q;
  assign bus.out_freq    = best_freq_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_caf_search_ctrl.sv
// Directed bench for caf_search_ctrl with four frequency bins.
module tb_caf_search_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   run_cnt  = 0;
  int   run_base;

  caf_search_ctrl_if #(.freq_bits(2), .index_bits(4), .mag_bits(24)) bus ();

  caf_search_ctrl #(
    .freq_bins     (4),
    .freq_bits     (2),
    .index_bits    (4),
    .mag_bits      (24),
    .timeout_cycles(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Count run_start pulses as seen by the datapath
  always @(posedge clk) if (bus.run_start === 1'b1) run_cnt++;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_freq_sel"}, 32'(bus.freq_sel), 0);
    check({tag, "_run_start"}, 32'(bus.run_start), 0);
    check({tag, "_in_tready"}, 32'(bus.in_tready), 0);
    check({tag, "_out_tvalid"}, 32'(bus.out_tvalid), 0);
    check({tag, "_out_max"}, 32'(bus.out_max), 0);
    check({tag, "_out_index"}, 32'(bus.out_index), 0);
    check({tag, "_out_freq"}, 32'(bus.out_freq), 0);
    check({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
  endtask

  // Serve one bin: find its LAUNCH, optionally inject a spurious result there,
  // then answer after one idle WAIT cycle.
  task automatic serve_bin(input int sel, input logic [23:0] m, input logic [4:0] idx,
                           input int exp_wait, input bit spur);
    int n = 0;
    while (bus.run_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("run_start_seen", 32'(bus.run_start), 1);
    check("launch_latency", n, exp_wait);
    check("freq_sel", 32'(bus.freq_sel), sel);
    if (spur) begin
      bus.in_tvalid = 1'b1;
      bus.in_max    = 24'hffffff;
      bus.in_index  = 5'h1f;
    end
    @(negedge clk);
    bus.in_tvalid = 1'b0;
    check("in_tready_wait1", 32'(bus.in_tready), 1);
    @(negedge clk);
    check("in_tready_wait2", 32'(bus.in_tready), 1);
    bus.in_tvalid = 1'b1;
    bus.in_max    = m;
    bus.in_index  = idx;
    @(negedge clk);
    bus.in_tvalid = 1'b0;
    check("in_tready_update", 32'(bus.in_tready), 0);
    check("run_start_update", 32'(bus.run_start), 0);
  endtask

  task automatic wait_emit(input logic [23:0] m, input logic [4:0] idx, input int fr);
    int n = 0;
    while (bus.out_tvalid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_tvalid", 32'(bus.out_tvalid), 1);
    check("emit_latency", n, 1);
    check("out_max", 32'(bus.out_max), 32'(m));
    check("out_index", 32'(bus.out_index), 32'(idx));
    check("out_freq", 32'(bus.out_freq), fr);
    check("busy_emit", 32'(bus.busy), 1);
  endtask

  task automatic finish_emit();
    bus.out_tready = 1'b1;
    @(negedge clk);
    bus.out_tready = 1'b0;
    check("out_tvalid_drop", 32'(bus.out_tvalid), 0);
    check("busy_drop", 32'(bus.busy), 0);
  endtask

  task automatic begin_search();
    run_base  = run_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 1);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.in_tvalid  = 1'b0;
    bus.in_max     = '0;
    bus.in_index   = '0;
    bus.out_tready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Distinct peaks: bin 1 wins
    begin_search();
    serve_bin(0, 24'd10, 5'd3, 0, 0);
    serve_bin(1, 24'd50, 5'd7, 1, 0);
    serve_bin(2, 24'd30, 5'd1, 1, 0);
    serve_bin(3, 24'd20, 5'd9, 1, 0);
    wait_emit(24'd50, 5'd7, 1);
    check("timeout_err_clear", 32'(bus.timeout_err), 0);
    // Backpressure with an ignored start
    for (int i = 0; i < 5; i++) begin
      bus.start = (i >= 1);
      @(negedge clk);
      check("hold_tvalid", 32'(bus.out_tvalid), 1);
      check("hold_max", 32'(bus.out_max), 50);
      check("hold_index", 32'(bus.out_index), 7);
      check("hold_freq", 32'(bus.out_freq), 1);
      check("hold_busy", 32'(bus.busy), 1);
      check("hold_no_launch", 32'(bus.run_start), 0);
    end
    bus.start = 1'b0;
    check("run_count_1", run_cnt - run_base, 4);
    finish_emit();
    @(negedge clk);
    check("start_not_queued", 32'(bus.run_start), 0);
    check("idle_after_emit", 32'(bus.busy), 0);
    check("freq_sel_holds", 32'(bus.freq_sel), 3);

    // Spurious result while idle
    bus.in_tvalid = 1'b1;
    bus.in_max    = 24'hffffff;
    bus.in_index  = 5'h1f;
    @(negedge clk);
    bus.in_tvalid = 1'b0;
    check("idle_tready", 32'(bus.in_tready), 0);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_keep_max", 32'(bus.out_max), 50);
    check("idle_keep_index", 32'(bus.out_index), 7);

    // Ties, with spurious results during LAUNCH of bins 0 and 2
    begin_search();
    serve_bin(0, 24'd40, 5'd2, 0, 1);
    serve_bin(1, 24'd40, 5'd4, 1, 0);
    serve_bin(2, 24'd40, 5'd6, 1, 1);
    serve_bin(3, 24'd40, 5'd8, 1, 0);
    wait_emit(24'd40, 5'd2, 0);
    check("run_count_2", run_cnt - run_base, 4);
    finish_emit();

    // All zero magnitudes
    begin_search();
    serve_bin(0, 24'd0, 5'd5, 0, 0);
    serve_bin(1, 24'd0, 5'd1, 1, 0);
    serve_bin(2, 24'd0, 5'd2, 1, 0);
    serve_bin(3, 24'd0, 5'd3, 1, 0);
    wait_emit(24'd0, 5'd5, 0);
    finish_emit();

    // Reset while waiting on bin 2
    begin_search();
    serve_bin(0, 24'd100, 5'd2, 0, 0);
    serve_bin(1, 24'd200, 5'd3, 1, 0);
    @(negedge clk);
    check("pre_abort_launch", 32'(bus.run_start), 1);
    check("pre_abort_sel", 32'(bus.freq_sel), 2);
    @(negedge clk);
    check("pre_abort_wait", 32'(bus.in_tready), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_emit", 32'(bus.out_tvalid), 0);
    begin_search();
    serve_bin(0, 24'd5, 5'd1, 0, 0);
    serve_bin(1, 24'd6, 5'd2, 1, 0);
    serve_bin(2, 24'd7, 5'd3, 1, 0);
    serve_bin(3, 24'd8, 5'd4, 1, 0);
    wait_emit(24'd8, 5'd4, 3);
    check("run_count_3", run_cnt - run_base, 4);
    finish_emit();

`ifdef CAF_SEARCH_TIMEOUT_EN
    // Bin 1 never answers
    begin
      int waits = 0;
      begin_search();
      serve_bin(0, 24'd10, 5'd1, 0, 0);
      @(negedge clk);
      check("to_launch", 32'(bus.run_start), 1);
      check("to_sel", 32'(bus.freq_sel), 1);
      @(negedge clk);
      while (bus.in_tready === 1'b1 && waits < 100) begin
        waits++;
        @(negedge clk);
      end
      check("to_wait_cycles", waits, 16);
      check("to_err_set", 32'(bus.timeout_err), 1);
      serve_bin(2, 24'd30, 5'd4, 1, 0);
      serve_bin(3, 24'd20, 5'd6, 1, 0);
      wait_emit(24'd30, 5'd4, 2);
      check("to_err_sticky", 32'(bus.timeout_err), 1);
      finish_emit();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
